// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, raster totals and sink FSM encoding.
package vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_RGB_WIDTH = 12;
  localparam int DEF_CNT_WIDTH = 11;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // The SOF flag sits directly above the colour bits of a pixel beat.
  localparam int SOF_BIT = DEF_RGB_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEEK = 2'b01,
    RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/vga_pixel_sink_timing_cnt.sv
// Raster h/v counters with enable-clear; decodes active area, sync windows and the frame origin.
module vga_timing_cnt #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CNT_WIDTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_act,
  output logic o_hs_i,
  output logic o_vs_i,
  output logic o_at_origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT_C  = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_ACT_C  = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] HS_START = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] HS_END   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_START = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] VS_END   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_WIDTH-1:0] r_h_cnt;
  logic [CNT_WIDTH-1:0] r_v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + C_ONE;
    end else begin
      r_h_cnt <= r_h_cnt + C_ONE;
    end
  end

  assign o_act       = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign o_hs_i      = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign o_vs_i      = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
  assign o_at_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_pixel_sink.sv
// VGA output stage: pulls one pixel beat per active cycle, registers pad outputs,
// flags underflow / SOF misalignment and resynchronises on the next frame origin.
module vga_pixel_sink
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter int   RGB_WIDTH = DEF_RGB_WIDTH,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 src_vld,
  input  logic [RGB_WIDTH:0]   src_pld,
  output logic                 src_rdy,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic [RGB_WIDTH-1:0] vga_rgb,
  output logic                 frame_start,
  output logic                 underflow
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_run;
  logic w_act;
  logic w_hs_i;
  logic w_vs_i;
  logic w_at_origin;
  logic w_sof;
  logic w_rdy;
  logic w_de_nxt;
  logic w_fs_nxt;
  logic w_uf_nxt;
  logic w_hs_nxt;
  logic w_vs_nxt;
  logic [RGB_WIDTH-1:0] w_rgb_nxt;

  logic r_hs;
  logic r_vs;
  logic r_de;
  logic r_fs;
  logic r_uf;
  logic [RGB_WIDTH-1:0] r_rgb;

  // Counters only advance once the FSM has left IDLE, so SEEK always starts at (0,0).
  assign w_run = en && (r_state != IDLE);
  assign w_sof = src_pld[RGB_WIDTH];

  vga_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .o_act      (w_act),
    .o_hs_i     (w_hs_i),
    .o_vs_i     (w_vs_i),
    .o_at_origin(w_at_origin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_de_nxt    = 1'b0;
    w_rgb_nxt   = '0;
    w_fs_nxt    = 1'b0;
    w_uf_nxt    = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = SEEK;
        SEEK: begin
          // Drain stray beats; an SOF waits at the head until the raster origin.
          if (src_vld && !w_sof) begin
            w_rdy = 1'b1;
          end else if (src_vld && w_sof && w_at_origin) begin
            w_rdy       = 1'b1;
            w_de_nxt    = 1'b1;
            w_rgb_nxt   = src_pld[RGB_WIDTH-1:0];
            w_fs_nxt    = 1'b1;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (w_act) begin
            w_de_nxt = 1'b1;
            w_rdy    = 1'b1;
            if (!src_vld) begin
              w_uf_nxt    = 1'b1;
              w_state_nxt = SEEK;
            end else if (w_sof != w_at_origin) begin
              w_rdy       = 1'b0;
              w_uf_nxt    = 1'b1;
              w_state_nxt = SEEK;
            end else begin
              w_rgb_nxt = src_pld[RGB_WIDTH-1:0];
              w_fs_nxt  = w_at_origin;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_hs_nxt = (w_run && w_hs_i) ? HS_POL : ~HS_POL;
  assign w_vs_nxt = (w_run && w_vs_i) ? VS_POL : ~VS_POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_rgb <= '0;
      r_fs  <= 1'b0;
      r_uf  <= 1'b0;
    end else begin
      r_hs  <= w_hs_nxt;
      r_vs  <= w_vs_nxt;
      r_de  <= w_de_nxt;
      r_rgb <= w_rgb_nxt;
      r_fs  <= w_fs_nxt;
      r_uf  <= w_uf_nxt;
    end
  end

  assign src_rdy     = w_rdy;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_de      = r_de;
  assign vga_rgb     = r_rgb;
  assign frame_start = r_fs;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Scoreboard bench for vga_pixel_sink on a 8x6-cycle raster (4x3 active).
module tb_vga_pixel_sink;

  localparam int RGBW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            src_vld = 1'b0;
  logic [RGBW:0]   src_pld = '0;
  logic            src_rdy;
  logic            vga_hs;
  logic            vga_vs;
  logic            vga_de;
  logic [RGBW-1:0] vga_rgb;
  logic            frame_start;
  logic            underflow;

  vga_pixel_sink #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .RGB_WIDTH(RGBW), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_WIDTH(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .src_vld(src_vld), .src_pld(src_pld),
    .src_rdy(src_rdy), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_rgb(vga_rgb), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [RGBW-1:0] rgb;
    logic            uf;
    logic            fs;
  } exp_t;

  exp_t          exp_q[$];
  logic [RGBW:0] src_q[$];
  bit            rdy_log[int];
  bit            fire_log[int];

  int cyc = 0;
  int t0 = 0;
  int vectors = 0;
  int miscompares = 0;
  bit tim_on = 1'b0;
  int tim_lim = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Index of the raster cycle in progress, counted from the first cycle after enable.
  function automatic int rel();
    return cyc - t0 - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, rel());
    end
  endtask

  // Every displayed pixel, underflow or frame_start pulse must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (vga_de || underflow || frame_start)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pixel: unexpected output at cycle %0d de=%b rgb=%h uf=%b fs=%b",
                 rel(), vga_de, vga_rgb, underflow, frame_start);
      end else begin
        e = exp_q.pop_front();
        if (rel() != e.cyc || vga_de !== 1'b1 || vga_rgb !== e.rgb ||
            underflow !== e.uf || frame_start !== e.fs) begin
          miscompares++;
          $display("FAIL pixel: got cycle=%0d de=%b rgb=%h uf=%b fs=%b, expected cycle=%0d de=1 rgb=%h uf=%b fs=%b",
                   rel(), vga_de, vga_rgb, underflow, frame_start, e.cyc, e.rgb, e.uf, e.fs);
        end
      end
    end
  end

  // Sync pads show the counters of the previous cycle: hs low at h=5,6; vs low at v=4.
  always @(negedge clk) begin
    int k;
    k = rel() - 1;
    if (tim_on && rst_n && k >= 0 && k <= tim_lim) begin
      check("hsync", {31'd0, vga_hs}, ((k % 8) >= 5 && (k % 8) <= 6) ? 32'd0 : 32'd1);
      check("vsync", {31'd0, vga_vs}, (((k / 8) % 6) == 4) ? 32'd0 : 32'd1);
    end
  end

  task automatic drive_src();
    src_vld = (src_q.size() > 0);
    src_pld = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  task automatic step();
    bit fire;
    int c;
    @(negedge clk);
    c = rel();
    fire = src_vld && src_rdy;
    rdy_log[c] = src_rdy;
    fire_log[c] = fire;
    @(posedge clk);
    #1;
    if (fire) void'(src_q.pop_front());
    drive_src();
  endtask

  task automatic run_until(input int target);
    while (rel() < target) step();
  endtask

  function automatic int fires(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++)
      if (fire_log.exists(c) && fire_log[c]) n++;
    return n;
  endfunction

  task automatic push_frame(input logic [RGBW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic sof;
      sof = (i == 0);
      src_q.push_back({sof, RGBW'(base + RGBW'(i))});
    end
  endtask

  task automatic expect_pix(input int c, input logic [RGBW-1:0] rgb, input logic uf, input logic fs);
    exp_t e;
    e.cyc = c; e.rgb = rgb; e.uf = uf; e.fs = fs;
    exp_q.push_back(e);
  endtask

  // Pixel idx of a frame whose origin is cycle c0 is accepted at c0+8*line+h and shown one cycle later.
  task automatic expect_frame(input int c0, input logic [RGBW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      expect_pix(c0 + (i / 4) * 8 + (i % 4) + 1, RGBW'(base + RGBW'(i)), 1'b0, (i == 0));
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    en = 1'b1;
    t0 = cyc;
    rdy_log.delete();
    fire_log.delete();
    drive_src();
  endtask

  task automatic end_scn(input string name);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    src_q.delete();
    en = 1'b0;
    drive_src();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic scen_stream();
    push_frame(12'd0, 12);
    push_frame(12'd12, 12);
    expect_frame(0, 12'd0, 12);
    expect_frame(48, 12'd12, 12);
    start();
    tim_lim = 92;
    tim_on = 1'b1;
    run_until(93);
    en = 1'b0;
    run_until(96);
    tim_on = 1'b0;
    check("s1_first_sof_accept", fire_log[0], 1);
    check("s1_beats_frame0", fires(0, 47), 12);
    check("s1_beats_frame1", fires(48, 92), 12);
    check("s1_rdy_after_en_low", rdy_log[93], 0);
    check("s1_pads_idle", {vga_hs, vga_vs, vga_de, 12'(vga_rgb)}, {1'b1, 1'b1, 1'b0, 12'd0});
    end_scn("s1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", rel());
    $fatal(1, "watchdog");
  end

  initial begin
    drive_src();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_de", vga_de, 0);
    check("rst_rgb", vga_rgb, 0);
    check("rst_fs", frame_start, 0);
    check("rst_uf", underflow, 0);
    check("rst_rdy", src_rdy, 0);
    #3 rst_n = 1'b1;

    // Always-valid stream from reset.
    scen_stream();

    // Three stray beats ahead of the SOF.
    src_q.push_back({1'b0, 12'hA01});
    src_q.push_back({1'b0, 12'hA02});
    src_q.push_back({1'b0, 12'hA03});
    push_frame(12'h100, 12);
    expect_frame(48, 12'h100, 12);
    start();
    run_until(70);
    en = 1'b0;
    run_until(72);
    for (int c = 0; c < 3; c++) check("s2_drain_rdy", rdy_log[c], 1);
    check("s2_sof_wait_rdy3", rdy_log[3], 0);
    check("s2_sof_wait_rdy47", rdy_log[47], 0);
    check("s2_no_accept_before_origin", fires(3, 47), 0);
    check("s2_sof_accept_origin", fire_log[48], 1);
    end_scn("s2");

    // Stream runs dry at pixel 6 (line 1, h=2).
    push_frame(12'h200, 6);
    expect_frame(0, 12'h200, 6);
    expect_pix(11, 12'd0, 1'b1, 1'b0);
    expect_frame(48, 12'h300, 12);
    start();
    run_until(11);
    push_frame(12'h300, 12);
    drive_src();
    run_until(70);
    en = 1'b0;
    run_until(72);
    check("s3_beats_before_uf", fires(0, 47), 6);
    check("s3_sof_held", rdy_log[11], 0);
    check("s3_recover_origin", fire_log[48], 1);
    end_scn("s3");

    // SOF arrives early at pixel 5.
    push_frame(12'h400, 5);
    push_frame(12'h500, 12);
    expect_frame(0, 12'h400, 5);
    expect_pix(10, 12'd0, 1'b1, 1'b0);
    expect_frame(48, 12'h500, 12);
    start();
    run_until(70);
    en = 1'b0;
    run_until(72);
    check("s4_mis_sof_rdy", rdy_log[9], 0);
    check("s4_beats_frame0", fires(0, 47), 5);
    check("s4_sof_accept_origin", fire_log[48], 1);
    end_scn("s4");

    // Enable dropped at (h=2, v=1), then restored.
    push_frame(12'h600, 12);
    expect_frame(0, 12'h600, 6);
    start();
    run_until(10);
    en = 1'b0;
    run_until(11);
    check("s5_pads_off", {vga_hs, vga_vs, vga_de, 12'(vga_rgb)}, {1'b1, 1'b1, 1'b0, 12'd0});
    check("s5_rdy_en_low", rdy_log[10], 0);
    src_q.delete();
    drive_src();
    run_until(13);
    push_frame(12'h700, 12);
    expect_frame(14, 12'h700, 12);
    en = 1'b1;
    drive_src();
    run_until(40);
    en = 1'b0;
    run_until(42);
    check("s5_rdy_idle", rdy_log[11], 0);
    check("s5_no_accept_idle", fires(11, 13), 0);
    check("s5_restart_origin", fire_log[14], 1);
    end_scn("s5");

    // Asynchronous reset in the middle of a displayed line.
    push_frame(12'h800, 12);
    expect_frame(0, 12'h800, 6);
    start();
    run_until(11);
    check("s6_pre_de", vga_de, 1);
    check("s6_pre_rgb", vga_rgb, 12'h806);
    #1 rst_n = 1'b0;
    #1;
    check("s6_async_hs", vga_hs, 1);
    check("s6_async_vs", vga_vs, 1);
    check("s6_async_de", vga_de, 0);
    check("s6_async_rgb", vga_rgb, 0);
    check("s6_async_fs", frame_start, 0);
    check("s6_async_uf", underflow, 0);
    check("s6_async_rdy", src_rdy, 0);
    en = 1'b0;
    end_scn("s6");
    scen_stream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
